ahbvga_sync_gen: RTL and testbench

Parametrised AHB-Lite VGA timing generator, successor to the fixed 640x480 sync logic inside the AHB VGA peripheral. Produces HSYNC/VSYNC, an active-video flag, pixel coordinates and a pixel clock-enable from configurable porch/sync/active parameters and a clock divider. An AHB-Lite register slave provides enable, sync polarity, frame-start interrupt and a frame counter. It sits between the AHB bus and the pixel/RGB pipeline of the VGA peripheral.

---
 rtl/ahbvga_sync_gen_if.sv | 23 ++
 rtl/ahbvga_sync_gen.sv | 181 ++++++++++++++++++
 tb/tb_ahbvga_sync_gen.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ahbvga_sync_gen_if.sv
// AHB-Lite slave bus bundle for the VGA timing generator.
// The master modport drives the request side; the slave modport returns
// read data and the ready-out.
interface ahbvga_sync_gen_if;
  logic        hsel;
  logic        hwrite;
  logic        hready;
  logic [1:0]  htrans;
  logic [31:0] haddr;
  logic [31:0] hwdata;
  logic [31:0] hrdata;
  logic        hreadyout;

  modport master (
    output hsel, hwrite, hready, htrans, haddr, hwdata,
    input  hrdata, hreadyout
  );

  modport slave (
    input  hsel, hwrite, hready, htrans, haddr, hwdata,
    output hrdata, hreadyout
  );
endinterface

// File: rtl/ahbvga_sync_gen.sv
// Parametrised VGA timing generator with an AHB-Lite register slave.
// Produces hsync/vsync, active-video flag, pixel coordinates and a pixel
// clock-enable. Registers: CTRL (0x0), STATUS (0x4), FRAME (0x8),
// POSITION (0xC, present only when VGA_SYNC_POS_REG_EN is defined).
module ahbvga_sync_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int CLK_DIV  = 2,
  parameter int CNT_W    = 11
) (
  input  logic               clk,
  input  logic               rst,
  ahbvga_sync_gen_if.slave   bus,
  output logic               hsync,
  output logic               vsync,
  output logic               active,
  output logic [CNT_W-1:0]   pix_x,
  output logic [CNT_W-1:0]   pix_y,
  output logic               pix_ce,
  output logic               irq
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  // Data-phase state captured from the address phase
  logic       dp_valid_reg, dp_write_reg;
  logic [1:0] dp_addr_reg;

  // Register file: ctrl = {irq_en, vpol, hpol, en}
  logic [3:0]  ctrl_reg, ctrl_next;
  logic        flag_reg, flag_next;
  logic [15:0] frame_reg, frame_next;

  // Timing counters and registered video outputs
  logic [DIV_W-1:0] div_reg, div_next;
  logic [CNT_W-1:0] h_reg, h_next, v_reg, v_next;
  logic             hsync_reg, hsync_next;
  logic             vsync_reg, vsync_next;
  logic             active_reg, active_next;

  logic        run, wrap, w1c, ce;
  logic [31:0] rdata;
  logic        unused_bits;

  assign unused_bits = ^{bus.haddr[31:4], bus.haddr[1:0], bus.hwdata[31:4], bus.htrans[0]};

  // Capture address-phase control whenever the bus advances
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dp_valid_reg <= 1'b0;
      dp_write_reg <= 1'b0;
      dp_addr_reg  <= 2'd0;
    end else if (bus.hready) begin
      dp_valid_reg <= bus.hsel & bus.htrans[1];
      dp_write_reg <= bus.hwrite;
      dp_addr_reg  <= bus.haddr[3:2];
    end
  end

  // Register writes, frame-flag set/clear (set wins) and frame counter
  always_comb begin
    ctrl_next = ctrl_reg;
    w1c       = 1'b0;
    if (dp_valid_reg && dp_write_reg) begin
      if (dp_addr_reg == 2'd0) ctrl_next = bus.hwdata[3:0];
      if (dp_addr_reg == 2'd1) w1c = bus.hwdata[0];
    end
    flag_next  = wrap ? 1'b1 : (w1c ? 1'b0 : flag_reg);
    frame_next = wrap ? frame_reg + 16'd1 : frame_reg;
  end

  // Counters advance only while enabled before and after this edge, so a
  // disabling write zeroes them on the same edge that clears EN
  assign ce  = ctrl_reg[0] && (div_reg == DIV_LAST);
  assign run = ctrl_reg[0] && ctrl_next[0];

  // Divider / horizontal / vertical next-state and syncs from next coordinates
  always_comb begin
    div_next = '0;
    h_next   = '0;
    v_next   = '0;
    wrap     = 1'b0;
    if (run) begin
      div_next = (div_reg == DIV_LAST) ? '0 : div_reg + DIV_W'(1);
      h_next   = h_reg;
      v_next   = v_reg;
      if (ce) begin
        if (h_reg == H_LAST) begin
          h_next = '0;
          if (v_reg == V_LAST) begin
            v_next = '0;
            wrap   = 1'b1;
          end else begin
            v_next = v_reg + CNT_W'(1);
          end
        end else begin
          h_next = h_reg + CNT_W'(1);
        end
      end
    end
    hsync_next  = (ctrl_next[0] && h_next >= HS_START && h_next < HS_END) ?
                  ctrl_next[1] : ~ctrl_next[1];
    vsync_next  = (ctrl_next[0] && v_next >= VS_START && v_next < VS_END) ?
                  ctrl_next[2] : ~ctrl_next[2];
    active_next = ctrl_next[0] && (h_next < H_ACT) && (v_next < V_ACT);
  end

  // State registers for registers, counters and video outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_reg   <= 4'd0;
      flag_reg   <= 1'b0;
      frame_reg  <= 16'd0;
      div_reg    <= '0;
      h_reg      <= '0;
      v_reg      <= '0;
      hsync_reg  <= 1'b1;
      vsync_reg  <= 1'b1;
      active_reg <= 1'b0;
    end else begin
      ctrl_reg   <= ctrl_next;
      flag_reg   <= flag_next;
      frame_reg  <= frame_next;
      div_reg    <= div_next;
      h_reg      <= h_next;
      v_reg      <= v_next;
      hsync_reg  <= hsync_next;
      vsync_reg  <= vsync_next;
      active_reg <= active_next;
    end
  end

  // Read mux decoded from the captured address during the data phase
  always_comb begin
    rdata = 32'd0;
    if (dp_valid_reg && !dp_write_reg) begin
      case (dp_addr_reg)
        2'd0: rdata[3:0] = ctrl_reg;
        2'd1: rdata[1:0] = {(v_reg >= V_ACT), flag_reg};
        2'd2: rdata[15:0] = frame_reg;
        default: begin
`ifdef VGA_SYNC_POS_REG_EN
          rdata[CNT_W-1:0]  = h_reg;
          rdata[16 +: CNT_W] = v_reg;
`else
          rdata = 32'd0;
`endif
        end
      endcase
    end
  end

  assign bus.hrdata    = rdata;
  assign bus.hreadyout = 1'b1;
  assign hsync         = hsync_reg;
  assign vsync         = vsync_reg;
  assign active        = active_reg;
  assign pix_x         = h_reg;
  assign pix_y         = v_reg;
  assign pix_ce        = ce;
  assign irq           = flag_reg & ctrl_reg[3];

endmodule

// File: tb/tb_ahbvga_sync_gen.sv
// Bench for ahbvga_sync_gen with a reduced raster so whole frames fit in a
// short run. Expected video outputs come from an arithmetic model: pixel
// index = cycles-since-enable / CLK_DIV, then h/v/frame by division.
module tb_ahbvga_sync_gen;
  localparam int HA = 8, HFP = 2, HS = 3, HBP = 2;
  localparam int VA = 5, VFP = 1, VS = 2, VBP = 1;
  localparam int D  = 3;
  localparam int W  = 11;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int FR = D * HT * VT;

  logic clk = 1'b0;
  logic rst;
  logic hsync, vsync, active, pix_ce, irq;
  logic [W-1:0] pix_x, pix_y;

  always #5 clk = ~clk;

  ahbvga_sync_gen_if bus();

  ahbvga_sync_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .CLK_DIV(D), .CNT_W(W)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .hsync(hsync), .vsync(vsync), .active(active),
    .pix_x(pix_x), .pix_y(pix_y), .pix_ce(pix_ce), .irq(irq)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // model state
  bit en_m, hpol_m, vpol_m, irqen_m, flag_m;
  int en_edge, seen, frame_base;

  typedef struct {
    logic        wr;
    logic [1:0]  tr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int frames_of(int k);
    return (k / D) / (HT * VT);
  endfunction

  function automatic logic [26:0] exp_out(int k);
    int n, h, v;
    logic [10:0] x, y;
    logic ce, hs, vs, act;
    if (en_m) begin
      n   = k / D;
      h   = n % HT;
      v   = (n / HT) % VT;
      ce  = (k % D) == D - 1;
      hs  = (h >= HA + HFP && h < HA + HFP + HS) ? hpol_m : !hpol_m;
      vs  = (v >= VA + VFP && v < VA + VFP + VS) ? vpol_m : !vpol_m;
      act = (h < HA) && (v < VA);
      x   = 11'(h);
      y   = 11'(v);
    end else begin
      x = 0; y = 0; ce = 0; act = 0;
      hs = !hpol_m; vs = !vpol_m;
    end
    return {x, y, ce, hs, vs, act, flag_m & irqen_m};
  endfunction

  function automatic logic [31:0] status_of(int k);
    int v;
    v = en_m ? ((k / D) / HT) % VT : 0;
    return {30'd0, (v >= VA), flag_m};
  endfunction

  function automatic logic [31:0] pos_of(int k);
    logic [31:0] r;
    r = 32'd0;
`ifdef VGA_SYNC_POS_REG_EN
    if (en_m) begin
      r[10:0]  = 11'((k / D) % HT);
      r[26:16] = 11'(((k / D) / HT) % VT);
    end
`endif
    return r;
  endfunction

  task automatic sync_flag(input int k);
    if (en_m && frames_of(k) > seen) begin
      flag_m = 1'b1;
      seen   = frames_of(k);
    end
  endtask

  // CTRL write landing on the edge counted by cyc
  task automatic model_ctrl(input logic [3:0] c);
    if (en_m && !c[0]) begin
      sync_flag(cyc - en_edge - 1);
      frame_base = frame_base + seen;
      en_m = 1'b0;
    end else if (!en_m && c[0]) begin
      en_m    = 1'b1;
      en_edge = cyc;
      seen    = 0;
    end
    hpol_m  = c[1];
    vpol_m  = c[2];
    irqen_m = c[3];
  endtask

  task automatic model_w1c();
    if (en_m) sync_flag(cyc - en_edge - 1);
    flag_m = 1'b0;
    if (en_m) sync_flag(cyc - en_edge);
  endtask

  function automatic logic [31:0] frame_exp();
    return 32'((frame_base + (en_m ? seen : 0)) & 16'hFFFF);
  endfunction

  task automatic step_check();
    int k;
    @(negedge clk);
    k = cyc - en_edge;
    sync_flag(k);
    check("video", {pix_x, pix_y, pix_ce, hsync, vsync, active, irq}, exp_out(k));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step_check();
  endtask

  task automatic ahb_write(input logic [31:0] a, input logic [31:0] d, input logic [1:0] tr);
    @(negedge clk);
    bus.hsel = 1'b1; bus.htrans = tr; bus.hwrite = 1'b1; bus.haddr = a;
    @(negedge clk);
    bus.hsel = 1'b0; bus.htrans = 2'b00; bus.hwrite = 1'b0; bus.hwdata = d;
    @(posedge clk);
    #1;
    if (tr[1] && a[3:2] == 2'd0) model_ctrl(d[3:0]);
    if (tr[1] && a[3:2] == 2'd1 && d[0]) model_w1c();
  endtask

  task automatic ahb_read(input logic [31:0] a, output logic [31:0] d, output int k);
    @(negedge clk);
    bus.hsel = 1'b1; bus.htrans = 2'b10; bus.hwrite = 1'b0; bus.haddr = a;
    @(negedge clk);
    bus.hsel = 1'b0; bus.htrans = 2'b00;
    d = bus.hrdata;
    k = cyc - en_edge;
    sync_flag(k);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic [3:0]  pol;
    int k, target, m;

    en_m = 0; hpol_m = 0; vpol_m = 0; irqen_m = 0; flag_m = 0;
    en_edge = 0; seen = 0; frame_base = 0;
    bus.hsel = 0; bus.hwrite = 0; bus.hready = 1; bus.htrans = 0;
    bus.haddr = 0; bus.hwdata = 0;
    rst = 1'b1;

    tbl[0] = '{1'b0, 2'b10, 32'h0,  32'h0,        32'h0};
    tbl[1] = '{1'b1, 2'b10, 32'h0,  32'hFFFFFFFE, 32'h0};
    tbl[2] = '{1'b0, 2'b10, 32'h0,  32'h0,        32'hE};
    tbl[3] = '{1'b0, 2'b10, 32'h10, 32'h0,        32'hE};
    tbl[4] = '{1'b1, 2'b10, 32'h8,  32'h1234,     32'h0};
    tbl[5] = '{1'b0, 2'b10, 32'h8,  32'h0,        32'h0};
    tbl[6] = '{1'b0, 2'b10, 32'h4,  32'h0,        32'h0};
    tbl[7] = '{1'b1, 2'b00, 32'h0,  32'h1,        32'h0};
    tbl[8] = '{1'b0, 2'b10, 32'hC,  32'h0,        32'h0};
    tbl[9] = '{1'b1, 2'b10, 32'h0,  32'h0,        32'h0};

    // reset values
    repeat (3) @(negedge clk);
    check("rst_hrdata", bus.hrdata, 0);
    check("rst_hreadyout", bus.hreadyout, 1);
    check("rst_video", {pix_x, pix_y, pix_ce, hsync, vsync, active, irq}, {22'd0, 5'b01100});
    rst = 1'b0;
    $display("reset released");

    // register table (EN stays 0)
    for (int i = 0; i < 10; i++) begin
      if (tbl[i].wr) begin
        ahb_write(tbl[i].addr, tbl[i].data, tbl[i].tr);
        $display("tbl %0d write addr=%0h data=%0h", i, tbl[i].addr, tbl[i].data);
      end else begin
        ahb_read(tbl[i].addr, rd, k);
        check($sformatf("tbl%0d_rd", i), rd, tbl[i].exp);
        $display("tbl %0d read addr=%0h data=%0h", i, tbl[i].addr, rd);
      end
      step_check();
      if (i == 1) check("idle_syncs_pol", {hsync, vsync}, 2'b00);
    end

    // enable with random polarity, run past one frame
    pol = 4'($urandom_range(0, 3));
    ahb_write(32'h0, {29'd0, pol[1:0], 1'b1}, 2'b10);
    $display("enable ctrl=%0h at cycle %0d", {pol[1:0], 1'b1}, cyc);
    run(FR + $urandom_range(20, 120));
    ahb_read(32'h8, rd, k);
    check("frame_after_run", rd, frame_exp());
    $display("read FRAME=%0h", rd);
    ahb_read(32'h4, rd, k);
    check("status_after_run", rd, status_of(k));
    $display("read STATUS=%0h", rd);
    ahb_read(32'hC, rd, k);
    check("position", rd, pos_of(k));
    $display("read POSITION=%0h", rd);

    // flip polarity mid-line and enable IRQ, then W1C the flag
    run($urandom_range(1, 40));
    ahb_write(32'h0, {28'd0, 1'b1, ~pol[1], ~pol[0], 1'b1}, 2'b10);
    $display("polarity flip + irq_en at cycle %0d", cyc);
    run(10);
    ahb_write(32'h4, 32'h1, 2'b10);
    $display("W1C status at cycle %0d", cyc);
    run(5);

    // W1C on the exact frame-wrap edge: set must win
    m = (cyc + 3 - en_edge + FR - 1) / FR;
    target = en_edge + m * FR;
    while (cyc < target - 3) step_check();
    ahb_write(32'h4, 32'h1, 2'b10);
    check("set_wins_edge", cyc, target);
    check("set_wins_irq", irq, 1);
    $display("W1C on wrap edge cycle %0d irq=%0b", cyc, irq);
    ahb_read(32'h4, rd, k);
    check("set_wins_status", rd, status_of(k));

    // disable mid-frame, then re-enable
    run($urandom_range(30, 200));
    ahb_write(32'h0, 32'h0, 2'b10);
    $display("disable at cycle %0d", cyc);
    check("disable_now", {pix_x, pix_y, hsync, vsync, active}, {22'd0, 3'b110});
    run(4);
    ahb_read(32'h8, rd, k);
    check("frame_after_disable", rd, frame_exp());
    ahb_read(32'hC, rd, k);
    check("position_disabled", rd, 0);
    pol = 4'($urandom_range(0, 3));
    ahb_write(32'h0, {29'd0, pol[1:0], 1'b1}, 2'b10);
    $display("re-enable at cycle %0d", cyc);
    run(FR / 2);

    // asynchronous reset mid-run
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_video", {pix_x, pix_y, pix_ce, hsync, vsync, active, irq}, {22'd0, 5'b01100});
    en_m = 0; hpol_m = 0; vpol_m = 0; irqen_m = 0; flag_m = 0; seen = 0; frame_base = 0;
    @(negedge clk);
    rst = 1'b0;
    ahb_read(32'h8, rd, k);
    check("async_rst_frame", rd, 0);
    ahb_read(32'h0, rd, k);
    check("async_rst_ctrl", rd, 0);
    run(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
